// File: rtl/multi_digit_auth.sv
// multi_digit_auth: keypad-style code checker with a consecutive-failure lockout.
// Digits are collected MSB-first into a buffer and compared against expected_code
// when enter is pressed. Too many consecutive failures lock the unit out for a
// fixed number of cycles. An abandoned entry is dropped after an inactivity timeout.
//
// state   | meaning
// IDLE    | no digits stored; waiting for the first digit
// ENTRY   | collecting digits; clear > enter > digit_valid
// GRANTED | access granted; only clear (log out) is honoured
// LOCKOUT | failure limit reached; every input ignored until the timer expires
module multi_digit_auth #(
  parameter int DIGITS         = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             digit_valid,
  input  logic [DIGIT_W-1:0]               digit,
  input  logic                             enter,
  input  logic                             clear,
  input  logic [DIGITS*DIGIT_W-1:0]        expected_code,
  output logic                             auth_status,
  output logic                             locked,
  output logic                             fail_pulse,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
  output logic [$clog2(DIGITS+1)-1:0]      entered
);

  localparam int CW = DIGITS * DIGIT_W;
  localparam int EW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [EW-1:0] FULL      = EW'(DIGITS);
  localparam logic [FW-1:0] FAIL_LIM  = FW'(MAX_FAILS);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    GRANTED = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t          r_state,      w_state_nxt;
  logic [CW-1:0]   r_buf,        w_buf_nxt;
  logic [EW-1:0]   r_entered,    w_entered_nxt;
  logic            r_ovf,        w_ovf_nxt;
  logic [TW-1:0]   r_tmo,        w_tmo_nxt;
  logic [LW-1:0]   r_lock,       w_lock_nxt;
  logic [FW-1:0]   r_fail_count, w_fail_count_nxt;
  logic            r_fail_pulse, w_fail_pulse_nxt;
  logic            r_auth,       w_auth_nxt;
  logic            r_locked,     w_locked_nxt;

  logic            w_match;
  logic [FW-1:0]   w_fail_inc;

  // Comparison is only consumed in the enter cycle, so expected_code is
  // effectively sampled only then.
  assign w_match    = (r_entered == FULL) && !r_ovf && (r_buf == expected_code);
  assign w_fail_inc = r_fail_count + FW'(1);

  // State register and all registered datapath/outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_buf        <= '0;
      r_entered    <= '0;
      r_ovf        <= 1'b0;
      r_tmo        <= '0;
      r_lock       <= '0;
      r_fail_count <= '0;
      r_fail_pulse <= 1'b0;
      r_auth       <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_buf        <= w_buf_nxt;
      r_entered    <= w_entered_nxt;
      r_ovf        <= w_ovf_nxt;
      r_tmo        <= w_tmo_nxt;
      r_lock       <= w_lock_nxt;
      r_fail_count <= w_fail_count_nxt;
      r_fail_pulse <= w_fail_pulse_nxt;
      r_auth       <= w_auth_nxt;
      r_locked     <= w_locked_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_buf_nxt        = r_buf;
    w_entered_nxt    = r_entered;
    w_ovf_nxt        = r_ovf;
    w_tmo_nxt        = r_tmo;
    w_lock_nxt       = r_lock;
    w_fail_count_nxt = r_fail_count;
    w_fail_pulse_nxt = 1'b0;
    w_auth_nxt       = r_auth;
    w_locked_nxt     = r_locked;

    case (r_state)
      IDLE: begin
        if (digit_valid) begin
          w_buf_nxt                    = '0;
          w_buf_nxt[CW-1 -: DIGIT_W]   = digit;
          w_entered_nxt                = EW'(1);
          w_ovf_nxt                    = 1'b0;
          w_tmo_nxt                    = TMO_LOAD;
          w_state_nxt                  = ENTRY;
        end
      end

      ENTRY: begin
        if (clear) begin
          w_buf_nxt     = '0;
          w_entered_nxt = '0;
          w_ovf_nxt     = 1'b0;
          w_state_nxt   = IDLE;
        end else if (enter) begin
          // The buffer is wiped on both outcomes so no code lingers in flops.
          w_buf_nxt     = '0;
          w_entered_nxt = '0;
          w_ovf_nxt     = 1'b0;
          if (w_match) begin
            w_auth_nxt       = 1'b1;
            w_fail_count_nxt = '0;
            w_state_nxt      = GRANTED;
          end else begin
            w_fail_pulse_nxt = 1'b1;
            w_fail_count_nxt = w_fail_inc;
            if (w_fail_inc == FAIL_LIM) begin
              w_locked_nxt = 1'b1;
              w_lock_nxt   = LOCK_LOAD;
              w_state_nxt  = LOCKOUT;
            end else begin
              w_state_nxt  = IDLE;
            end
          end
        end else if (digit_valid) begin
          w_tmo_nxt = TMO_LOAD;
          if (r_entered < FULL) begin
            for (int k = 0; k < DIGITS; k++) begin
              if (int'(r_entered) == k) begin
                w_buf_nxt[(DIGITS-1-k)*DIGIT_W +: DIGIT_W] = digit;
              end
            end
            w_entered_nxt = r_entered + EW'(1);
          end else begin
            w_ovf_nxt = 1'b1;
          end
        end else if (r_tmo == '0) begin
          // Final idle cycle of the timeout window: abandon silently.
          w_buf_nxt     = '0;
          w_entered_nxt = '0;
          w_ovf_nxt     = 1'b0;
          w_state_nxt   = IDLE;
        end else begin
          w_tmo_nxt = r_tmo - TW'(1);
        end
      end

      GRANTED: begin
        if (clear) begin
          w_auth_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end

      LOCKOUT: begin
        if (r_lock == '0) begin
          w_locked_nxt     = 1'b0;
          w_fail_count_nxt = '0;
          w_state_nxt      = IDLE;
        end else begin
          w_lock_nxt = r_lock - LW'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign auth_status = r_auth;
  assign locked      = r_locked;
  assign fail_pulse  = r_fail_pulse;
  assign fail_count  = r_fail_count;
  assign entered     = r_entered;

endmodule

// File: tb/tb_multi_digit_auth.sv
// tb_multi_digit_auth: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based reference model of the access rules.
module tb_multi_digit_auth;

  localparam int          DIGITS = 4;
  localparam int          DW     = 4;
  localparam int          MAXF   = 3;
  localparam int          LOCKC  = 16;
  localparam int          TMOC   = 8;
  localparam logic [15:0] CODE   = 16'hA15C;

  logic        clk = 1'b0;
  logic        reset;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        enter;
  logic        clear;
  logic [15:0] expected_code;
  logic        auth_status;
  logic        locked;
  logic        fail_pulse;
  logic [1:0]  fail_count;
  logic [2:0]  entered;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_q[$];
  bit m_ovf;
  int m_idle;
  int m_lock_left;
  bit m_grant;
  int m_fail;
  bit m_pulse;

  multi_digit_auth #(
    .DIGITS(DIGITS), .DIGIT_W(DW), .MAX_FAILS(MAXF),
    .LOCKOUT_CYCLES(LOCKC), .TIMEOUT_CYCLES(TMOC)
  ) dut (
    .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .clear(clear), .expected_code(expected_code),
    .auth_status(auth_status), .locked(locked), .fail_pulse(fail_pulse),
    .fail_count(fail_count), .entered(entered)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf       = 0;
    m_idle      = 0;
    m_lock_left = 0;
    m_grant     = 0;
    m_fail      = 0;
    m_pulse     = 0;
  endtask

  function automatic int packed_code();
    int v = 0;
    foreach (m_q[i]) v = v + (m_q[i] << (4 * (DIGITS - 1 - i)));
    return v;
  endfunction

  // Advances the model by one clock edge with the given inputs.
  task automatic model_step(input bit dv, input int d, input bit en, input bit clr);
    m_pulse = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fail = 0;
    end else if (m_grant) begin
      if (clr) m_grant = 0;
    end else if (m_q.size() == 0) begin
      if (dv) begin
        m_q.push_back(d);
        m_ovf  = 0;
        m_idle = 0;
      end
    end else if (clr) begin
      m_q.delete();
    end else if (en) begin
      if (m_q.size() == DIGITS && !m_ovf && packed_code() == int'(CODE)) begin
        m_grant = 1;
        m_fail  = 0;
      end else begin
        m_pulse = 1;
        m_fail++;
        if (m_fail == MAXF) m_lock_left = LOCKC;
      end
      m_q.delete();
    end else if (dv) begin
      m_idle = 0;
      if (m_q.size() < DIGITS) m_q.push_back(d);
      else m_ovf = 1;
    end else begin
      m_idle++;
      if (m_idle == TMOC) m_q.delete();
    end
  endtask

  task automatic check_all();
    chk("auth_status", auth_status, m_grant);
    chk("locked", locked, m_lock_left > 0);
    chk("fail_pulse", fail_pulse, m_pulse);
    chk("fail_count", fail_count, m_fail);
    chk("entered", entered, m_q.size());
    chk("auth_and_locked", auth_status & locked, 0);
  endtask

  // Called at a falling edge: drive, advance model, wait one cycle, compare.
  task automatic step(input bit dv, input logic [3:0] d, input bit en, input bit clr);
    digit_valid   = dv;
    digit         = d;
    enter         = en;
    clear         = clr;
    expected_code = en ? CODE : 16'($urandom);
    model_step(dv, int'(d), en, clr);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic feed(input logic [15:0] c, input int n);
    for (int i = 0; i < n; i++) step(1'b1, c[15 - 4*i -: 4], 1'b0, 1'b0);
  endtask

  task automatic wrong_entry();
    feed(16'h1234, 4);
    step(1'b0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic idle_step();
    step(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int lock_len;
    int r;
    reset         = 1'b1;
    digit_valid   = 1'b0;
    digit         = '0;
    enter         = 1'b0;
    clear         = 1'b0;
    expected_code = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    reset = 1'b0;

    // correct code grants, clear logs out
    feed(CODE, 4);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("grant_auth", auth_status, 1);
    chk("grant_fail_count", fail_count, 0);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    chk("logout_auth", auth_status, 0);

    // short entry fails, overflowed entry fails
    feed(CODE, 3);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("short_pulse", fail_pulse, 1);
    chk("short_fail_count", fail_count, 1);
    idle_step();
    chk("pulse_one_cycle", fail_pulse, 0);
    feed(CODE, 4);
    step(1'b1, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("ovf_fail_count", fail_count, 2);
    chk("ovf_auth", auth_status, 0);
    feed(CODE, 4);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // three failures lock out for exactly LOCKC cycles; code is ignored meanwhile
    wrong_entry();
    wrong_entry();
    wrong_entry();
    chk("lock_start", locked, 1);
    lock_len = 1;
    for (int i = 0; i < 40 && locked; i++) begin
      if (i % 5 == 4) step(1'b0, 4'h0, 1'b1, 1'b0);
      else step(1'b1, CODE[15 - 4*(i%5) -: 4], 1'b0, 1'b0);
      if (locked) lock_len++;
    end
    chk("lock_len", lock_len, LOCKC);
    chk("lock_end_fail_count", fail_count, 0);
    chk("lock_end_auth", auth_status, 0);

    // inactivity timeout abandons the entry without a failure
    feed(CODE, 2);
    repeat (TMOC - 1) idle_step();
    chk("tmo_not_yet", entered, 2);
    idle_step();
    chk("tmo_entered", entered, 0);
    chk("tmo_pulse", fail_pulse, 0);
    feed(CODE, 4);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("tmo_then_grant", auth_status, 1);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // input priority
    feed(CODE, 4);
    step(1'b0, 4'h0, 1'b1, 1'b1);
    chk("clr_enter_auth", auth_status, 0);
    chk("clr_enter_pulse", fail_pulse, 0);
    chk("clr_enter_entered", entered, 0);
    feed(CODE, 4);
    step(1'b1, 4'h7, 1'b1, 1'b0);
    chk("enter_dv_auth", auth_status, 1);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // asynchronous reset mid-lockout
    wrong_entry();
    wrong_entry();
    wrong_entry();
    repeat (4) idle_step();
    chk("pre_reset_locked", locked, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_fail_count", fail_count, 0);
    chk("rst_entered", entered, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    feed(CODE, 4);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("post_rst_grant", auth_status, 1);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // randomized traffic, biased toward the correct next digit
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] d;
      int nxt;
      nxt = m_q.size() < DIGITS ? m_q.size() : 0;
      d = ($urandom_range(0, 9) < 7) ? CODE[15 - 4*nxt -: 4] : 4'($urandom);
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 59) == 0) repeat (TMOC + 1) idle_step();
      else if (r < 45) step(1'b1, d, 1'b0, 1'b0);
      else if (r < 55) step(1'b0, d, 1'b1, 1'b0);
      else if (r < 60) step(1'b0, d, 1'b0, 1'b1);
      else if (r < 64) step(1'($urandom), d, 1'($urandom), 1'($urandom));
      else idle_step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
